// File: rtl/put_sequencer.sv
// put_sequencer: serialises one operation request (0..MAXOPS operand bytes plus an
// ALU op code) into putEn operand beats followed by a single opEn beat, one beat
// per clock, with a downstream hold that freezes beat issue.
module put_sequencer #(
  parameter int unsigned W      = 8,
  parameter int unsigned OPW    = 4,
  parameter int unsigned MAXOPS = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [1:0]     req_count,
  input  logic [W-1:0]   req_val0,
  input  logic [W-1:0]   req_val1,
  input  logic [W-1:0]   req_val2,
  input  logic [OPW-1:0] req_op,
  input  logic           hold,
  output logic           putEn,
  output logic [W-1:0]   value,
  output logic           opEn,
  output logic [OPW-1:0] op_code,
  output logic           done
);

  typedef enum logic [1:0] {StIdle, StPut, StOp} state_e;

  localparam logic [1:0] MaxCnt = 2'(MAXOPS);

  state_e         state_q, state_d;
  logic [1:0]     count_q;
  logic [1:0]     idx_q;
  logic [W-1:0]   val0_q, val1_q, val2_q;
  logic [OPW-1:0] op_q;
  logic           done_q;

  logic           accept;
  logic [1:0]     count_clamped;

  assign accept        = req_valid & req_ready;
  assign count_clamped = (req_count > MaxCnt) ? MaxCnt : req_count;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; the OP beat can hand over directly to a newly accepted request
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = (count_clamped != 2'd0) ? StPut : StOp;
      end
      StPut: begin
        if (!hold && (idx_q == count_q - 2'd1)) state_d = StOp;
      end
      StOp: begin
        if (!hold) begin
          if (accept) state_d = (count_clamped != 2'd0) ? StPut : StOp;
          else        state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Request latches, operand index and the done pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      idx_q   <= '0;
      val0_q  <= '0;
      val1_q  <= '0;
      val2_q  <= '0;
      op_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      if (accept) begin
        count_q <= count_clamped;
        idx_q   <= '0;
        val0_q  <= req_val0;
        val1_q  <= req_val1;
        val2_q  <= req_val2;
        op_q    <= req_op;
      end else if ((state_q == StPut) && !hold) begin
        idx_q <= idx_q + 2'd1;
      end
      done_q <= (state_q == StOp) && !hold;
    end
  end

  // Outputs decoded from registered state and latches; buses are zero off-beat
  always_comb begin
    req_ready = (state_q == StIdle) || ((state_q == StOp) && !hold);
    putEn     = (state_q == StPut) && !hold;
    opEn      = (state_q == StOp) && !hold;
    value     = '0;
    op_code   = '0;
    done      = done_q;
    if (putEn) begin
      unique case (idx_q)
        2'd0:    value = val0_q;
        2'd1:    value = val1_q;
        default: value = val2_q;
      endcase
    end
    if (opEn) op_code = op_q;
  end

endmodule

// File: tb/tb_put_sequencer.sv
// Bench for put_sequencer: a beat-queue reference model predicts every output each
// cycle; directed scenarios plus a randomized run.
module tb_put_sequencer;

  localparam int unsigned W      = 8;
  localparam int unsigned OPW    = 4;
  localparam int unsigned MAXOPS = 3;

  logic           clk;
  logic           reset;
  logic           req_valid;
  logic           req_ready;
  logic [1:0]     req_count;
  logic [W-1:0]   req_val0, req_val1, req_val2;
  logic [OPW-1:0] req_op;
  logic           hold;
  logic           putEn;
  logic [W-1:0]   value;
  logic           opEn;
  logic [OPW-1:0] op_code;
  logic           done;

  put_sequencer #(.W(W), .OPW(OPW), .MAXOPS(MAXOPS)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_count (req_count),
    .req_val0  (req_val0),
    .req_val1  (req_val1),
    .req_val2  (req_val2),
    .req_op    (req_op),
    .hold      (hold),
    .putEn     (putEn),
    .value     (value),
    .opEn      (opEn),
    .op_code   (op_code),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the beats still owed for the current request, in issue order
  typedef struct packed {
    logic         is_op;
    logic [W-1:0] v;
  } beat_t;

  beat_t q[$];
  bit    m_done;

  int n_cmp;
  int n_err;
  int cyc;

  // {req_ready, putEn, value, opEn, op_code, done}
  logic [W+OPW+3:0] obs, exp_v;

  function automatic logic [W+OPW+3:0] model_out();
    logic           rdy, pe, oe;
    logic [W-1:0]   v;
    logic [OPW-1:0] oc;
    rdy = (q.size() == 0) || (q.size() == 1 && !hold);
    pe  = 1'b0; oe = 1'b0; v = '0; oc = '0;
    if (q.size() > 0 && !hold) begin
      if (q[0].is_op) begin
        oe = 1'b1;
        oc = q[0].v[OPW-1:0];
      end else begin
        pe = 1'b1;
        v  = q[0].v;
      end
    end
    return {rdy, pe, v, oe, oc, m_done};
  endfunction

  task automatic push_req();
    int unsigned n;
    logic [W-1:0] vals [3];
    beat_t b;
    vals[0] = req_val0; vals[1] = req_val1; vals[2] = req_val2;
    n = (int'(req_count) > MAXOPS) ? MAXOPS : int'(req_count);
    for (int i = 0; i < int'(n); i++) begin
      b.is_op = 1'b0;
      b.v     = vals[i];
      q.push_back(b);
    end
    b.is_op = 1'b1;
    b.v     = W'(req_op);
    q.push_back(b);
  endtask

  // Wait to mid-cycle and capture observed and predicted outputs
  task automatic settle();
    @(negedge clk);
    obs   = {req_ready, putEn, value, opEn, op_code, done};
    exp_v = model_out();
  endtask

  // Apply the rising edge to the model, then leave time for new inputs
  task automatic advance();
    bit rdy, issued, was_op;
    @(posedge clk);
    rdy    = (q.size() == 0) || (q.size() == 1 && !hold);
    issued = (q.size() > 0) && !hold;
    was_op = issued && q[0].is_op;
    if (issued) void'(q.pop_front());
    if (req_valid && rdy) push_req();
    m_done = was_op;
    cyc++;
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0; hold = 1'b0; req_count = '0;
    req_val0 = '0; req_val1 = '0; req_val2 = '0; req_op = '0;
  endtask

  task automatic test_reset();
    logic [W+OPW+3:0] want;
    idle_inputs();
    reset = 1'b0;
    #2;
    want = {1'b1, 1'b0, {W{1'b0}}, 1'b0, {OPW{1'b0}}, 1'b0};
    obs  = {req_ready, putEn, value, opEn, op_code, done};
    n_cmp++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL reset_state: got %h want %h", obs, want);
    end
    q.delete(); m_done = 0;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      settle(); n_cmp++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL reset_idle cyc %0d: got %h want %h", cyc, obs, exp_v);
      end
      advance();
    end
  endtask

  task automatic test_count3();
    int puts, rdy_low, ops;
    logic [W-1:0] seen [$];
    puts = 0; rdy_low = 0; ops = 0;
    idle_inputs();
    req_valid = 1'b1; req_count = 2'd3;
    req_val0 = 8'h11; req_val1 = 8'h22; req_val2 = 8'h33; req_op = 4'h5;
    for (int i = 0; i < 6; i++) begin
      settle(); n_cmp++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL count3 cyc %0d: got %h want %h", cyc, obs, exp_v);
      end
      if (putEn) begin puts++; seen.push_back(value); end
      if (opEn && op_code == 4'h5) ops++;
      if (i > 0 && !req_ready) rdy_low++;
      advance();
      req_valid = 1'b0;
    end
    n_cmp++;
    if (puts !== 3 || rdy_low !== 3 || ops !== 1) begin
      n_err++; $display("FAIL count3_tally: got puts=%0d rdy_low=%0d ops=%0d want 3/3/1",
                        puts, rdy_low, ops);
    end
    n_cmp++;
    if (seen.size() != 3 || seen[0] !== 8'h11 || seen[1] !== 8'h22 || seen[2] !== 8'h33) begin
      n_err++; $display("FAIL count3_order: got %p want 11,22,33", seen);
    end
  endtask

  task automatic test_count0();
    int puts, ops;
    puts = 0; ops = 0;
    idle_inputs();
    req_valid = 1'b1; req_count = 2'd0; req_op = 4'hA;
    for (int i = 0; i < 4; i++) begin
      settle(); n_cmp++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL count0 cyc %0d: got %h want %h", cyc, obs, exp_v);
      end
      if (putEn) puts++;
      if (i == 1 && opEn && op_code == 4'hA) ops++;
      advance();
      req_valid = 1'b0;
    end
    n_cmp++;
    if (puts !== 0 || ops !== 1) begin
      n_err++; $display("FAIL count0_tally: got puts=%0d ops=%0d want 0/1", puts, ops);
    end
  endtask

  task automatic test_hold();
    idle_inputs();
    req_valid = 1'b1; req_count = 2'd3;
    req_val0 = 8'h11; req_val1 = 8'h22; req_val2 = 8'h33; req_op = 4'h7;
    for (int i = 0; i < 9; i++) begin
      hold = (i == 2 || i == 3);
      settle(); n_cmp++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL hold cyc %0d: got %h want %h", cyc, obs, exp_v);
      end
      advance();
      req_valid = 1'b0;
    end
    hold = 1'b0;
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    req_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      req_count = 2'd2;
      req_val0 = W'($urandom); req_val1 = W'($urandom); req_op = OPW'($urandom);
      settle(); n_cmp++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL back_to_back cyc %0d: got %h want %h", cyc, obs, exp_v);
      end
      advance();
    end
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle(); n_cmp++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL back_to_back_drain cyc %0d: got %h want %h", cyc, obs, exp_v);
      end
      advance();
    end
  endtask

  task automatic test_reset_mid_put();
    logic [W+OPW+3:0] want;
    idle_inputs();
    req_valid = 1'b1; req_count = 2'd3;
    req_val0 = 8'hA1; req_val1 = 8'hA2; req_val2 = 8'hA3; req_op = 4'h3;
    for (int i = 0; i < 2; i++) begin
      settle(); n_cmp++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL abort_pre cyc %0d: got %h want %h", cyc, obs, exp_v);
      end
      advance();
      req_valid = 1'b0;
    end
    // Second operand beat is now on the bus; pull reset without a clock edge
    reset = 1'b0;
    #1;
    want = {1'b1, 1'b0, {W{1'b0}}, 1'b0, {OPW{1'b0}}, 1'b0};
    obs  = {req_ready, putEn, value, opEn, op_code, done};
    n_cmp++;
    if (obs !== want) begin
      n_err++; $display("FAIL abort_async: got %h want %h", obs, want);
    end
    q.delete(); m_done = 0;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle(); n_cmp++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL abort_post cyc %0d: got %h want %h", cyc, obs, exp_v);
      end
      advance();
    end
  endtask

  task automatic test_ignore_inputs();
    idle_inputs();
    req_valid = 1'b1; req_count = 2'd3;
    req_val0 = 8'h5A; req_val1 = 8'h6B; req_val2 = 8'h7C; req_op = 4'h9;
    for (int i = 0; i < 8; i++) begin
      settle(); n_cmp++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL ignore cyc %0d: got %h want %h", cyc, obs, exp_v);
      end
      advance();
      req_val0 = W'($urandom); req_val1 = W'($urandom); req_val2 = W'($urandom);
      req_op = OPW'($urandom); req_count = 2'($urandom);
      req_valid = (i < 3);
    end
  endtask

  task automatic test_random();
    idle_inputs();
    for (int i = 0; i < 400; i++) begin
      req_valid = ($urandom_range(0, 9) < 7);
      hold      = ($urandom_range(0, 3) == 0);
      req_count = 2'($urandom);
      req_val0  = W'($urandom); req_val1 = W'($urandom); req_val2 = W'($urandom);
      req_op    = OPW'($urandom);
      settle(); n_cmp++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL random cyc %0d: got %h want %h", cyc, obs, exp_v);
      end
      advance();
    end
    idle_inputs();
  endtask

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0; m_done = 0;
    test_reset();
    test_count3();
    test_count0();
    test_hold();
    test_back_to_back();
    test_reset_mid_put();
    test_ignore_inputs();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
